// File: rtl/dmem_port_if.sv
// Request/response bus between a load-store unit and the dmem_port data memory.
interface dmem_port_if #(
    parameter int SIZE = 12
);
    logic [2:0]      memCtrl;
    logic            reqValid;
    logic            reqReady;
    logic [SIZE-1:0] addr;
    logic [31:0]     wdata;
    logic            rspValid;
    logic            rspReady;
    logic [31:0]     rdata;
    logic            rspErr;

    modport master (
        output memCtrl, reqValid, addr, wdata, rspReady,
        input  reqReady, rspValid, rdata, rspErr
    );

    modport slave (
        input  memCtrl, reqValid, addr, wdata, rspReady,
        output reqReady, rspValid, rdata, rspErr
    );
endinterface

// File: rtl/dmem_port.sv
// Byte-addressable data memory port: IDLE -> ACCESS -> RESP handshake FSM over 2^SIZE bytes.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning down.
module dmem_port #(
    parameter int SIZE = 12
) (
    input logic        clk,
    input logic        rst,
    dmem_port_if.slave bus
);
    localparam int WORDS = 1 << (SIZE - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [2:0] {
        OP_LB  = 3'b000, OP_LH  = 3'b001, OP_LW = 3'b010, OP_LBU = 3'b011,
        OP_LHU = 3'b100, OP_SB  = 3'b101, OP_SH = 3'b110, OP_SW  = 3'b111
    } op_t;

    state_t          r_state, w_next;
    op_t             r_ctrl;
    logic [SIZE-1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [WORDS];

    logic            w_accept;
    logic            w_misalign;
    logic [SIZE-3:0] w_word;
    logic [31:0]     w_rd;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wlanes;

    assign w_accept = bus.reqValid && bus.reqReady;
    assign w_word   = r_addr[SIZE-1:2];
    assign w_rd     = r_mem[w_word];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_err;

    always_comb begin
        w_misalign = 1'b0;
        case (r_ctrl)
            OP_LH, OP_LHU, OP_SH: w_misalign = r_addr[0];
            OP_LW, OP_SW:         w_misalign = |r_addr[1:0];
            default:              w_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (r_state == ACCESS)
            r_err <= w_misalign;
    end

    assign bus.rspErr = r_err && !rst;
`else
    assign w_misalign = 1'b0;
    assign bus.rspErr = 1'b0;
`endif

    always_comb begin
        w_byte = w_rd[{r_addr[1:0], 3'b000} +: 8];
        w_half = w_rd[{r_addr[1], 4'b0000} +: 16];
        w_load = '0;
        case (r_ctrl)
            OP_LB, OP_LBU: w_load = {24'b0, w_byte};
            OP_LH, OP_LHU: w_load = {16'b0, w_half};
            OP_LW:         w_load = w_rd;
            default:       w_load = '0;
        endcase
        if (w_misalign)
            w_load = '0;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_ctrl)
            OP_SB: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            OP_SH: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            OP_SW:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        if (w_misalign)
            w_be = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == ACCESS) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_word][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ctrl  <= op_t'(bus.memCtrl);
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ACCESS)
                r_rdata <= w_load;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.reqValid) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    if (bus.rspReady) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.reqReady = (r_state == IDLE) && !rst;
    assign bus.rspValid = (r_state == RESP) && !rst;
    assign bus.rdata    = rst ? '0 : r_rdata;
endmodule
